// File: rtl/processing_unit.sv
// processing_unit: FP16 (IEEE-754 half precision) adder built as a five-state
// machine (IDLE, ALIGN, ADD, NORM, DONE). Operands are captured in IDLE, the
// sum is rounded to nearest-even, and P is updated together with a one-cycle
// ready strobe. Subnormals are handled without flushing to zero.
module processing_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] P,
    output logic        ready
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t      state;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [13:0] big_sig;
    logic [13:0] small_sig;
    logic [4:0]  exp_big;
    logic        sign_big;
    logic        sub_op;
    logic        special;
    logic [15:0] special_val;
    logic [14:0] sum;
    logic [15:0] result;

    logic [15:0] big_op;
    logic [15:0] small_op;
    logic [4:0]  e_big_c;
    logic [4:0]  e_small_c;
    logic [4:0]  diff_c;
    logic [13:0] big_c;
    logic [13:0] small_full;
    logic [13:0] small_c;
    logic [27:0] wide_c;
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic        spec_c;
    logic [15:0] spec_val_c;

    logic [3:0]  lz;
    logic [6:0]  shamt;
    logic [6:0]  e_n;
    logic [6:0]  e_r;
    logic [13:0] m_n;
    logic [11:0] mant_rnd;
    logic [10:0] mant_f;
    logic        rnd_up;
    logic [15:0] result_c;

    // Unpack, order by magnitude, align the smaller significand (with GRS bits) and detect special operands
    always_comb begin
        big_op   = op_a;
        small_op = op_b;
        if (op_a[14:0] < op_b[14:0]) begin
            big_op   = op_b;
            small_op = op_a;
        end
        e_big_c    = (big_op[14:10] == 5'd0) ? 5'd1 : big_op[14:10];
        e_small_c  = (small_op[14:10] == 5'd0) ? 5'd1 : small_op[14:10];
        big_c      = {big_op[14:10] != 5'd0, big_op[9:0], 3'b000};
        small_full = {small_op[14:10] != 5'd0, small_op[9:0], 3'b000};
        diff_c     = e_big_c - e_small_c;
        wide_c     = {small_full, 14'd0} >> diff_c;
        if (diff_c >= 5'd14) begin
            small_c = {13'd0, |small_full};
        end else begin
            small_c = {wide_c[27:15], wide_c[14] | (|wide_c[13:0])};
        end

        a_nan  = (&op_a[14:10]) & (|op_a[9:0]);
        b_nan  = (&op_b[14:10]) & (|op_b[9:0]);
        a_inf  = (&op_a[14:10]) & ~(|op_a[9:0]);
        b_inf  = (&op_b[14:10]) & ~(|op_b[9:0]);
        a_zero = (op_a[14:0] == 15'd0);
        b_zero = (op_b[14:0] == 15'd0);

        spec_c     = 1'b0;
        spec_val_c = 16'h0000;
        if (a_nan || b_nan || (a_inf && b_inf && (op_a[15] != op_b[15]))) begin
            spec_c     = 1'b1;
            spec_val_c = 16'h7E00;
        end else if (a_inf) begin
            spec_c     = 1'b1;
            spec_val_c = op_a;
        end else if (b_inf) begin
            spec_c     = 1'b1;
            spec_val_c = op_b;
        end else if (a_zero && b_zero) begin
            spec_c     = 1'b1;
            spec_val_c = {op_a[15] & op_b[15], 15'd0};
        end
    end

    // Normalize the raw sum (clamped at exp=1 for gradual underflow), round to nearest-even and pack
    always_comb begin
        lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) lz = 4'(13 - i);
        end
        shamt = 7'd0;
        if (sum[14]) begin
            m_n = {sum[14:2], sum[1] | sum[0]};
            e_n = {2'b00, exp_big} + 7'd1;
        end else begin
            if ({3'b000, lz} < ({2'b00, exp_big} - 7'd1)) begin
                shamt = {3'b000, lz};
            end else begin
                shamt = {2'b00, exp_big} - 7'd1;
            end
            m_n = sum[13:0] << shamt;
            e_n = {2'b00, exp_big} - shamt;
        end

        rnd_up   = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
        mant_rnd = {1'b0, m_n[13:3]} + {11'd0, rnd_up};
        if (mant_rnd[11]) begin
            mant_f = mant_rnd[11:1];
            e_r    = e_n + 7'd1;
        end else begin
            mant_f = mant_rnd[10:0];
            e_r    = e_n;
        end

        if (special) begin
            result_c = special_val;
        end else if (sum == 15'd0) begin
            result_c = 16'h0000;
        end else if (e_r >= 7'd31) begin
            result_c = {sign_big, 5'h1F, 10'd0};
        end else begin
            result_c = {sign_big, mant_f[10] ? e_r[4:0] : 5'd0, mant_f[9:0]};
        end
    end

    // State machine and pipeline registers; P and ready are registered and updated only from DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_a        <= 16'd0;
            op_b        <= 16'd0;
            big_sig     <= 14'd0;
            small_sig   <= 14'd0;
            exp_big     <= 5'd0;
            sign_big    <= 1'b0;
            sub_op      <= 1'b0;
            special     <= 1'b0;
            special_val <= 16'd0;
            sum         <= 15'd0;
            result      <= 16'd0;
            P           <= 16'd0;
            ready       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        op_a  <= a;
                        op_b  <= b;
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    big_sig     <= big_c;
                    small_sig   <= small_c;
                    exp_big     <= e_big_c;
                    sign_big    <= big_op[15];
                    sub_op      <= op_a[15] ^ op_b[15];
                    special     <= spec_c;
                    special_val <= spec_val_c;
                    state       <= ADD;
                end
                ADD: begin
                    if (sub_op) begin
                        sum <= {1'b0, big_sig} - {1'b0, small_sig};
                    end else begin
                        sum <= {1'b0, big_sig} + {1'b0, small_sig};
                    end
                    state <= NORM;
                end
                NORM: begin
                    result <= result_c;
                    state  <= DONE;
                end
                DONE: begin
                    P     <= result;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_processing_unit.sv
// Directed testbench for processing_unit: reset behaviour, basic adds,
// cancellation/rounding, special values, back-to-back throughput and an
// asynchronous reset in the middle of an operation.
module tb_processing_unit;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] P;
    logic        ready;

    int passed;
    int total;

    processing_unit dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .a     (a),
        .b     (b),
        .P     (P),
        .ready (ready)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture one operand pair, then wait (bounded) for the ready strobe; lat counts edges after capture
    task automatic run_op(input logic [15:0] opa, input logic [15:0] opb,
                          output logic [15:0] p_out, output int lat);
        @(negedge clk);
        a  = opa;
        b  = opb;
        en = 1'b1;
        @(posedge clk);
        #1;
        en    = 1'b0;
        a     = $urandom_range(0, 65535);
        b     = $urandom_range(0, 65535);
        lat   = -1;
        p_out = 16'hxxxx;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat   = i;
                p_out = P;
                break;
            end
        end
    endtask

    // One full operation with result, latency and strobe-width comparisons
    task automatic check_add(input logic [15:0] opa, input logic [15:0] opb,
                             input logic [15:0] exp_p, input string name);
        logic [15:0] p_got;
        int          lat;
        run_op(opa, opb, p_got, lat);
        total++;
        if (lat !== 4) $display("[TB] FAIL %s latency: got %0d, want 4", name, lat);
        else passed++;
        total++;
        if (p_got !== exp_p) $display("[TB] FAIL %s result: got %h, want %h", name, p_got, exp_p);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b0) $display("[TB] FAIL %s ready width: got %b, want 0", name, ready);
        else passed++;
        total++;
        if (P !== exp_p) $display("[TB] FAIL %s hold: got %h, want %h", name, P, exp_p);
        else passed++;
    endtask

    // Reset held with en high: outputs stay cleared; after release the first en edge captures
    task automatic test_reset;
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 65535);
            b = $urandom_range(0, 65535);
            @(posedge clk);
            #1;
            total++;
            if (P !== 16'h0000 || ready !== 1'b0)
                $display("[TB] FAIL reset_hold: got P=%h ready=%b, want P=0000 ready=0", P, ready);
            else passed++;
        end
        @(negedge clk);
        en    = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (ready !== 1'b0) $display("[TB] FAIL reset_idle: got ready=%b, want 0", ready);
            else passed++;
        end
        check_add(16'h4400, 16'h4600, 16'h4900, "first_after_reset");
    endtask

    task automatic test_basic;
        check_add(16'h4000, 16'hC400, 16'hC000, "sub_neg");
        check_add(16'h3C00, 16'h3C00, 16'h4000, "one_plus_one");
    endtask

    task automatic test_cancel_round;
        check_add(16'h3C00, 16'hBC00, 16'h0000, "cancel");
        check_add(16'h3C00, 16'h1000, 16'h3C00, "tie_even");
        check_add(16'h3C00, 16'h1400, 16'h3C01, "exact_lsb");
        check_add(16'h8000, 16'h8000, 16'h8000, "neg_zeros");
        check_add(16'h0000, 16'h8000, 16'h0000, "mixed_zeros");
    endtask

    task automatic test_specials;
        check_add(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
        check_add(16'hFBFF, 16'hFBFF, 16'hFC00, "neg_overflow");
        check_add(16'h7C00, 16'hFC00, 16'h7E00, "inf_minus_inf");
        check_add(16'h7C01, 16'h3C00, 16'h7E00, "nan_in");
        check_add(16'hFC00, 16'h4400, 16'hFC00, "inf_plus_fin");
        check_add(16'h0001, 16'h0001, 16'h0002, "subnormal");
        check_add(16'h03FF, 16'h0001, 16'h0400, "sub_to_norm");
    endtask

    // en held high across three captures; operands scrambled between captures
    task automatic test_back_to_back;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] ve [3];
        int          strobes;
        va = '{16'h4000, 16'h03FF, 16'h3C00};
        vb = '{16'hC400, 16'h0001, 16'h3C00};
        ve = '{16'hC000, 16'h0400, 16'h4000};
        strobes = 0;
        @(negedge clk);
        a  = va[0];
        b  = vb[0];
        en = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                total++;
                if (strobes >= 3 || e != 5 * strobes + 4) begin
                    $display("[TB] FAIL b2b_timing: strobe %0d at edge %0d, want at edge %0d", strobes, e, 5 * strobes + 4);
                end else begin
                    passed++;
                    total++;
                    if (P !== ve[strobes]) $display("[TB] FAIL b2b_result%0d: got %h, want %h", strobes, P, ve[strobes]);
                    else passed++;
                end
                strobes++;
            end
            @(negedge clk);
            if (((e + 1) % 5 == 0) && ((e + 1) / 5 < 3)) begin
                a = va[(e + 1) / 5];
                b = vb[(e + 1) / 5];
            end else begin
                a = $urandom_range(0, 65535);
                b = $urandom_range(0, 65535);
            end
            if (e + 1 == 15) en = 1'b0;
        end
        total++;
        if (strobes !== 3) $display("[TB] FAIL b2b_count: got %0d strobes, want 3", strobes);
        else passed++;
    endtask

    // Reset asserted while the FSM sits in ADD: immediate clear, no strobe, clean restart
    task automatic test_reset_midop;
        int seen;
        check_add(16'h4400, 16'h4600, 16'h4900, "pre_abort");
        @(negedge clk);
        a  = 16'h3C00;
        b  = 16'h3C00;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (P !== 16'h0000 || ready !== 1'b0)
            $display("[TB] FAIL abort_clear: got P=%h ready=%b, want P=0000 ready=0", P, ready);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        total++;
        if (seen != 0) $display("[TB] FAIL abort_no_strobe: got %0d strobes, want 0", seen);
        else passed++;
        check_add(16'h4000, 16'hC400, 16'hC000, "restart");
    endtask

    // Top-level sequence with a global watchdog
    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b0;
        en     = 1'b0;
        a      = 16'h0000;
        b      = 16'h0000;
        test_reset();
        test_basic();
        test_cancel_round();
        test_specials();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
